univ_shift_reg: RTL and testbench

Parametrised universal shift register, the next generation of the team's fixed 5-bit serial shift register. It adds configurable width, bidirectional shift, rotate, parallel load and synchronous clear. It also counts shifts and pulses a flag when a frame of FRAME_LEN shifts completes. It serves as the common serializer/deserializer core for the SeqLogic library (SPI/UART-style framing, scan chains).

---
 rtl/univ_shift_reg.sv | 60 ++++++
 tb/tb_univ_shift_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register (shift/rotate/load/clear)
// with a per-frame shift counter and a registered frame-complete pulse.
module univ_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_LOAD = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift, is_last;
  always_comb begin
    is_shift = (op >= OP_SHL) && (op <= OP_ROR);
    is_last  = cnt_q == CNT_LAST;
    q_d = op == OP_SHL  ? {q_q[WIDTH-2:0], sin_lsb} :
          op == OP_SHR  ? {sin_msb, q_q[WIDTH-1:1]} :
          op == OP_ROL  ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} :
          op == OP_ROR  ? {q_q[0], q_q[WIDTH-1:1]} :
          op == OP_LOAD ? load_data :
          op == OP_CLR  ? '0 : q_q;
    cnt_d = is_shift ? (is_last ? '0 : cnt_q + CNT_W'(1)) :
            (op == OP_LOAD || op == OP_CLR) ? '0 : cnt_q;
    done_d = is_shift && is_last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
  assign q          = q_q;
  assign sout_msb   = q_q[WIDTH-1];
  assign sout_lsb   = q_q[0];
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: three configurations driven in lockstep, checked against
// an arithmetic reference model plus directed constants for the 8-bit instance.
module tb_univ_shift_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  op = 3'd0;
  logic        sin_lsb = 1'b0;
  logic        sin_msb = 1'b0;
  logic [31:0] ld = '0;
  logic [7:0]  q0;
  logic [4:0]  q1;
  logic [31:0] q2;
  logic [3:0]  c0;
  logic [2:0]  c1;
  logic [3:0]  c2;
  logic [2:0]  sm, sl, dn;
  logic [63:0] aq [3];
  logic [63:0] ac [3];
  int          n_chk = 0;
  int          n_err = 0;
  int          wid [3] = '{8, 5, 32};
  int          flen [3] = '{8, 5, 1};
  logic [63:0] mq [3];
  int          mcnt [3];
  logic        mdone [3];

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .FRAME_LEN(8), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .op(op), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
    .load_data(ld[7:0]), .q(q0), .sout_msb(sm[0]), .sout_lsb(sl[0]),
    .shift_cnt(c0), .frame_done(dn[0]));
  univ_shift_reg #(.WIDTH(5), .FRAME_LEN(5), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .op(op), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
    .load_data(ld[4:0]), .q(q1), .sout_msb(sm[1]), .sout_lsb(sl[1]),
    .shift_cnt(c1), .frame_done(dn[1]));
  univ_shift_reg #(.WIDTH(32), .FRAME_LEN(1), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .op(op), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
    .load_data(ld), .q(q2), .sout_msb(sm[2]), .sout_lsb(sl[2]),
    .shift_cnt(c2), .frame_done(dn[2]));

  assign aq[0] = 64'(q0);
  assign aq[1] = 64'(q1);
  assign aq[2] = 64'(q2);
  assign ac[0] = 64'(c0);
  assign ac[1] = 64'(c1);
  assign ac[2] = 64'(c2);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = '0;
      mcnt[i] = 0;
      mdone[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic [2:0] o, input logic s_l, input logic s_m,
                                     input logic [31:0] d);
    for (int i = 0; i < 3; i++) begin
      logic [63:0] mask, v;
      int w;
      w = wid[i];
      mask = (64'd1 << w) - 64'd1;
      v = mq[i];
      case (o)
        3'd1: v = ((v << 1) | 64'(s_l)) & mask;
        3'd2: v = (v >> 1) | (64'(s_m) << (w - 1));
        3'd3: v = ((v << 1) | (v >> (w - 1))) & mask;
        3'd4: v = (v >> 1) | ((v & 64'd1) << (w - 1));
        3'd5: v = 64'(d) & mask;
        3'd6: v = '0;
        default: ;
      endcase
      mq[i] = v;
      mdone[i] = 1'b0;
      if (o >= 3'd1 && o <= 3'd4) begin
        mcnt[i]++;
        if (mcnt[i] == flen[i]) begin
          mcnt[i] = 0;
          mdone[i] = 1'b1;
        end
      end else if (o == 3'd5 || o == 3'd6) begin
        mcnt[i] = 0;
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("q%0d", i), aq[i], mq[i]);
      check($sformatf("smsb%0d", i), 64'(sm[i]), (mq[i] >> (wid[i] - 1)) & 64'd1);
      check($sformatf("slsb%0d", i), 64'(sl[i]), mq[i] & 64'd1);
      check($sformatf("cnt%0d", i), ac[i], 64'(mcnt[i]));
      check($sformatf("done%0d", i), 64'(dn[i]), 64'(mdone[i]));
    end
  endtask

  task automatic step(input logic [2:0] o, input logic s_l, input logic s_m, input logic [31:0] d);
    op = o;
    sin_lsb = s_l;
    sin_msb = s_m;
    ld = d;
    @(posedge clk);
    model_step(o, s_l, s_m, d);
    #1;
    check_all();
  endtask

  task automatic async_rst();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    op = 3'd5;
    ld = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 check_all();
    check("rst_hold_q", 64'(q0), 64'h0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    check("reset_q", 64'(q0), 64'h0);
    rst = 1'b0;
    step(3'd5, 0, 0, 32'h0000_00A5);
    async_rst();
    check("async_q", 64'(q0), 64'h0);
    step(3'd5, 0, 0, 32'h0000_00A5);
    check("load_q", 64'(q0), 64'hA5);
    check("load_msb", 64'(sm[0]), 64'h1);
    check("load_lsb", 64'(sl[0]), 64'h1);
    step(3'd1, 1, 0, 32'h0);
    check("shl_q", 64'(q0), 64'h4B);
    check("shl_cnt", 64'(c0), 64'h1);
    step(3'd5, 0, 0, 32'h81);
    step(3'd3, 0, 0, 32'h0);
    check("rol_q", 64'(q0), 64'h03);
    step(3'd5, 0, 0, 32'h81);
    step(3'd4, 0, 0, 32'h0);
    check("ror_q", 64'(q0), 64'hC0);
    step(3'd5, 0, 0, 32'h01);
    step(3'd2, 0, 1, 32'h0);
    check("shr_q", 64'(q0), 64'h80);
    step(3'd6, 1, 1, 32'hFFFF_FFFF);
    check("clr_q", 64'(q0), 64'h0);
    check("clr_cnt", 64'(c0), 64'h0);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        step(3'd1, 1, 0, 32'h0);
        check($sformatf("frame%0d_done%0d", f, k), 64'(dn[0]), 64'(k == 7));
      end
      check("frame_q", 64'(q0), 64'hFF);
      check("frame_cnt", 64'(c0), 64'h0);
    end
    step(3'd6, 0, 0, 32'h0);
    repeat (3) step(3'd1, 1, 0, 32'h0);
    for (int k = 0; k < 5; k++) step((k % 2) ? 3'd7 : 3'd0, 1, 1, 32'hDEAD_BEEF);
    check("hold_cnt", 64'(c0), 64'h3);
    for (int k = 0; k < 5; k++) step(3'd1, 0, 0, 32'h0);
    check("hold_done", 64'(dn[0]), 64'h1);
    repeat (4) step(3'd2, 1, 1, 32'h0);
    step(3'd5, 0, 0, 32'h3C);
    check("abort_cnt", 64'(c0), 64'h0);
    check("abort_done", 64'(dn[0]), 64'h0);
    for (int k = 0; k < 8; k++) begin
      step(3'd3, 0, 0, 32'h0);
      check($sformatf("abort_done%0d", k), 64'(dn[0]), 64'(k == 7));
    end
    for (int k = 0; k < 600; k++) begin
      logic [2:0] o;
      o = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
      step(o, 1'($urandom), 1'($urandom), $urandom);
      if ($urandom_range(0, 60) == 0) async_rst();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
